// File: rtl/bicubic_phase_gen.sv
// Raster-scan source coordinate / blend-phase generator for the bicubic weight path (DDA accumulators).
// Build option: define CENTER_ALIGN_EN for pixel-centre mapping; otherwise corner mapping (X0 = Y0 = 0).
module bicubic_phase_gen #(
    parameter int IDX_W  = 12,
    parameter int FRAC_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [IDX_W-1:0]        src_w,
    input  logic [IDX_W-1:0]        src_h,
    input  logic [IDX_W-1:0]        dst_w,
    input  logic [IDX_W-1:0]        dst_h,
    input  logic [IDX_W+FRAC_W-1:0] step_x,
    input  logic [IDX_W+FRAC_W-1:0] step_y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IDX_W-1:0]        x_int,
    output logic [8:0]              x_blend,
    output logic [IDX_W-1:0]        y_int,
    output logic [8:0]              y_blend,
    output logic                    sol,
    output logic                    eol,
    output logic                    eof,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              o_dbg_state
);

    localparam int STEP_W = IDX_W + FRAC_W;
    localparam int ACC_W  = IDX_W + FRAC_W + 1;
    localparam logic [IDX_W-1:0] ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    // Handshake: a beat moves on any rising edge where out_valid && out_ready; while
    // out_valid && !out_ready every coordinate output holds its value.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_src_w, r_src_h, r_dst_w, r_dst_h;
    logic [STEP_W-1:0]   r_step_x, r_step_y;
    logic [ACC_W-1:0]    r_x0, r_y0;
    logic [ACC_W-1:0]    r_acc_x, r_acc_y;
    logic [IDX_W-1:0]    r_col, r_row;

    logic [ACC_W-1:0]    w_x0, w_y0;
    logic [ACC_W-1:0]    w_acc_x_inc, w_acc_y_inc;
    logic [IDX_W-1:0]    w_col_inc, w_row_inc;
    logic [IDX_W-1:0]    w_dst_w_m1, w_dst_h_m1;
    logic                w_xfer;

    // Integer part at or beyond the source edge (carry bit included) pins to the last pixel.
    function automatic logic [IDX_W+8:0] map_coord(input logic [ACC_W-1:0] acc,
                                                   input logic [IDX_W-1:0] lim);
        logic [IDX_W:0] ip;
        ip = acc[ACC_W-1:FRAC_W];
        if (ip >= {1'b0, lim})
            map_coord = {lim - ONE, 9'd0};
        else
            map_coord = {ip[IDX_W-1:0], 1'b0, acc[FRAC_W-1 -: 8]};
    endfunction

`ifdef CENTER_ALIGN_EN
    localparam logic [STEP_W-1:0] HALF_PIX = STEP_W'(1) << (FRAC_W - 1);

    function automatic logic [ACC_W-1:0] center_off(input logic [STEP_W-1:0] step);
        logic [STEP_W-1:0] half;
        half = step >> 1;
        if (half >= HALF_PIX)
            center_off = {1'b0, half - HALF_PIX};
        else
            center_off = '0;
    endfunction

    assign w_x0 = center_off(step_x);
    assign w_y0 = center_off(step_y);
`else
    assign w_x0 = '0;
    assign w_y0 = '0;
`endif

    // Once the carry bit is set the accumulator stays put; the clamp already covers it.
    assign w_acc_x_inc = r_acc_x[ACC_W-1] ? r_acc_x : r_acc_x + {1'b0, r_step_x};
    assign w_acc_y_inc = r_acc_y[ACC_W-1] ? r_acc_y : r_acc_y + {1'b0, r_step_y};
    assign w_col_inc   = r_col + ONE;
    assign w_row_inc   = r_row + ONE;
    assign w_dst_w_m1  = r_dst_w - ONE;
    assign w_dst_h_m1  = r_dst_h - ONE;
    assign w_xfer      = out_valid && out_ready;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_src_w   <= '0;
            r_src_h   <= '0;
            r_dst_w   <= '0;
            r_dst_h   <= '0;
            r_step_x  <= '0;
            r_step_y  <= '0;
            r_x0      <= '0;
            r_y0      <= '0;
            r_acc_x   <= '0;
            r_acc_y   <= '0;
            r_col     <= '0;
            r_row     <= '0;
            out_valid <= 1'b0;
            x_int     <= '0;
            x_blend   <= '0;
            y_int     <= '0;
            y_blend   <= '0;
            sol       <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src_w  <= src_w;
                        r_src_h  <= src_h;
                        r_dst_w  <= dst_w;
                        r_dst_h  <= dst_h;
                        r_step_x <= step_x;
                        r_step_y <= step_y;
                        r_x0     <= w_x0;
                        r_y0     <= w_y0;
                        if (dst_w == '0 || dst_h == '0) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state              <= S_RUN;
                            busy                 <= 1'b1;
                            out_valid            <= 1'b1;
                            r_acc_x              <= w_x0;
                            r_acc_y              <= w_y0;
                            r_col                <= '0;
                            r_row                <= '0;
                            {x_int, x_blend}     <= map_coord(w_x0, src_w);
                            {y_int, y_blend}     <= map_coord(w_y0, src_h);
                            sol                  <= 1'b1;
                            eol                  <= (dst_w == ONE);
                            eof                  <= (dst_w == ONE) && (dst_h == ONE);
                        end
                    end
                end
                S_RUN: begin
                    if (w_xfer) begin
                        if (eof) begin
                            r_state   <= S_DONE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            sol       <= 1'b0;
                            eol       <= 1'b0;
                            eof       <= 1'b0;
                        end else if (eol) begin
                            r_col            <= '0;
                            r_row            <= w_row_inc;
                            r_acc_x          <= r_x0;
                            r_acc_y          <= w_acc_y_inc;
                            {x_int, x_blend} <= map_coord(r_x0, r_src_w);
                            {y_int, y_blend} <= map_coord(w_acc_y_inc, r_src_h);
                            sol              <= 1'b1;
                            eol              <= (r_dst_w == ONE);
                            eof              <= (r_dst_w == ONE) && (w_row_inc == w_dst_h_m1);
                        end else begin
                            r_col            <= w_col_inc;
                            r_acc_x          <= w_acc_x_inc;
                            {x_int, x_blend} <= map_coord(w_acc_x_inc, r_src_w);
                            sol              <= 1'b0;
                            eol              <= (w_col_inc == w_dst_w_m1);
                            eof              <= (w_col_inc == w_dst_w_m1) && (r_row == w_dst_h_m1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bicubic_phase_gen.sv
// Scoreboard bench for bicubic_phase_gen: arithmetic reference model feeds exp_q, a negedge monitor pops and compares.
module tb_bicubic_phase_gen;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] src_w, src_h, dst_w, dst_h;
    logic [27:0] step_x, step_y;
    logic        out_valid, out_ready;
    logic [11:0] x_int, y_int;
    logic [8:0]  x_blend, y_blend;
    logic        sol, eol, eof, busy, done;
    logic [1:0]  o_dbg_state;

    logic [44:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_beats  = 0;
    int          ready_mode = 0;

    bicubic_phase_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_w(src_w), .src_h(src_h), .dst_w(dst_w), .dst_h(dst_h),
        .step_x(step_x), .step_y(step_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_int(x_int), .x_blend(x_blend), .y_int(y_int), .y_blend(y_blend),
        .sol(sol), .eol(eol), .eof(eof), .busy(busy), .done(done),
        .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: coordinate of dst (c, r) is X0 + c*step, Y0 + r*step in 16-bit fixed point
    task automatic push_expected(input int sw, input int sh, input int dw, input int dh,
                                 input longint sx, input longint sy);
        longint x0, y0, ax, ay, xi, xb, yi, yb;
        x0 = 0;
        y0 = 0;
`ifdef CENTER_ALIGN_EN
        x0 = (sx / 2 >= 32768) ? sx / 2 - 32768 : 0;
        y0 = (sy / 2 >= 32768) ? sy / 2 - 32768 : 0;
`endif
        for (int r = 0; r < dh; r++) begin
            for (int c = 0; c < dw; c++) begin
                ax = x0 + c * sx;
                ay = y0 + r * sy;
                xi = ax / 65536;
                yi = ay / 65536;
                xb = (ax / 256) % 256;
                yb = (ay / 256) % 256;
                if (xi >= sw) begin xi = sw - 1; xb = 0; end
                if (yi >= sh) begin yi = sh - 1; yb = 0; end
                exp_q.push_back({12'(xi), 9'(xb), 12'(yi), 9'(yb),
                                 c == 0, c == dw - 1, (c == dw - 1) && (r == dh - 1)});
            end
        end
    endtask

    // driver: present config, pulse start for one sampled edge, then scramble config
    task automatic kick(input int sw, input int sh, input int dw, input int dh,
                        input logic [27:0] sx, input logic [27:0] sy);
        @(posedge clk); #1;
        src_w  = 12'(sw);
        src_h  = 12'(sh);
        dst_w  = 12'(dw);
        dst_h  = 12'(dh);
        step_x = sx;
        step_y = sy;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        src_w  = 12'($urandom);
        src_h  = 12'($urandom);
        dst_w  = 12'($urandom);
        dst_h  = 12'($urandom);
        step_x = 28'($urandom);
        step_y = 28'($urandom);
        if (dw != 0 && dh != 0) begin
            check("first_valid_latency", out_valid, 1);
            check("busy_in_run", busy, 1);
        end else begin
            check("empty_frame_done", done, 1);
            check("empty_frame_no_valid", out_valid, 0);
        end
    endtask

    task automatic wait_done(input int bound, input bit poke);
        int i;
        for (i = 0; i < bound; i++) begin
            if (done) break;
            if (poke && i == 3) start = 1'b1;
            if (poke && i == 4) start = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("done_within_bound", (i < bound), 1);
        check("queue_drained_at_done", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("busy_clear_after_done", busy, 0);
    endtask

    task automatic run_frame(input int sw, input int sh, input int dw, input int dh,
                             input logic [27:0] sx, input logic [27:0] sy,
                             input int mode, input bit poke);
        ready_mode = mode;
        push_expected(sw, sh, dw, dh, longint'(sx), longint'(sy));
        kick(sw, sh, dw, dh, sx, sy);
        wait_done(4000, poke);
    endtask

    // out_ready driver: 0 always ready, 1 random, 2 periodic three-cycle stalls
    initial begin
        int cyc;
        cyc = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            cyc++;
            case (ready_mode)
                1:       out_ready = ($urandom_range(0, 3) != 0);
                2:       out_ready = !((cyc % 10) >= 4 && (cyc % 10) < 7);
                default: out_ready = 1'b1;
            endcase
        end
    end

    // monitor / scoreboard
    initial begin
        logic [45:0] held_val;
        logic [45:0] cur;
        bit          held;
        held = 0;
        forever begin
            @(negedge clk);
            cur = {out_valid, x_int, x_blend, y_int, y_blend, sol, eol, eof};
            if (!rst_n) begin
                held = 0;
            end else begin
                if (held) check("stall_hold", cur, held_val);
                held = 0;
                if (out_valid) begin
                    if (out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_beat", cur[44:0], 45'h0);
                            if (cur[44:0] == 45'h0) check("unexpected_beat_valid", 1, 0);
                        end else begin
                            check("beat", cur[44:0], exp_q.pop_front());
                        end
                        n_beats++;
                    end else begin
                        held = 1;
                        held_val = cur;
                    end
                end
            end
        end
    end

    initial begin
        int base;
        int k;
        rst_n  = 1'b0;
        start  = 1'b0;
        src_w  = '0; src_h = '0; dst_w = '0; dst_h = '0;
        step_x = '0; step_y = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_coords", {x_int, x_blend, y_int, y_blend, sol, eol, eof}, 0);
        check("reset_state", o_dbg_state, 0);
        rst_n = 1'b1;

        // 2x upscale, always ready
        run_frame(4, 2, 8, 4, 28'h8000, 28'h8000, 0, 0);
        // clamp at right edge
        run_frame(2, 1, 4, 1, 28'h10000, 28'h0, 0, 0);
        // empty frames
        run_frame(4, 4, 0, 3, 28'h8000, 28'h8000, 0, 0);
        run_frame(4, 4, 5, 0, 28'h8000, 28'h8000, 0, 0);
        // single-pixel frame: sol, eol, eof together
        run_frame(3, 3, 1, 1, 28'h12345, 28'h6789, 0, 0);
        // single-column frame
        run_frame(3, 5, 1, 4, 28'h8000, 28'h14000, 1, 0);
        // periodic three-cycle stalls, plus a start pulse while busy
        run_frame(4, 2, 8, 4, 28'h8000, 28'h8000, 2, 1);
        // downscale with fractions, and a maximal step that saturates the accumulator
        run_frame(20, 12, 7, 5, 28'h2C000, 28'h24CCC, 1, 0);
        run_frame(4095, 4095, 5, 3, 28'hFFFFFFF, 28'hFFFFFFF, 0, 0);

        // asynchronous reset after five beats, then restart at (0,0)
        ready_mode = 0;
        base = n_beats;
        push_expected(4, 2, 8, 4, 28'h8000, 28'h8000);
        kick(4, 2, 8, 4, 28'h8000, 28'h8000);
        for (k = 0; k < 100 && (n_beats - base) < 5; k++) begin
            @(posedge clk); #1;
        end
        check("reached_beat5", (n_beats - base) >= 5, 1);
        #1 rst_n = 1'b0;
        #1;
        check("midframe_reset_valid", out_valid, 0);
        check("midframe_reset_busy", busy, 0);
        check("midframe_reset_coords", {x_int, x_blend, y_int, y_blend, sol, eol, eof}, 0);
        check("midframe_reset_state", o_dbg_state, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("no_done_after_reset", done, 0);
        end
        run_frame(4, 2, 8, 4, 28'h8000, 28'h8000, 0, 0);

        // randomized frames with random backpressure
        for (int f = 0; f < 20; f++) begin
            run_frame($urandom_range(1, 20), $urandom_range(1, 20),
                      $urandom_range(1, 12), $urandom_range(1, 6),
                      28'($urandom_range(0, 32'h3FFFF)), 28'($urandom_range(0, 32'h3FFFF)),
                      1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
